// File: rtl/bcd_seg7_scan.sv
// Two-digit multiplexed 7-segment scanner for a 0..19 BCD value.
// Define LEADING_ZERO_BLANK_EN to blank the tens digit when it is zero.
module bcd_seg7_scan #(
  parameter int SCAN_CYCLES = 100000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       z,
  input  logic [3:0] bcd,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       err
);

  localparam int MAXC = (SCAN_CYCLES > GAP_CYCLES) ? SCAN_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SCAN_LD = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ONE   = 7'b1111001;
  localparam logic [6:0] ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    SHOW_ONES,
    GAP_A,
    SHOW_TENS,
    GAP_B
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    an_n;
  logic [6:0]    seg_n;
  logic          z_q;
  logic [3:0]    bcd_q;
  logic [1:0]    tens_an;
  logic [6:0]    tens_seg;

  function automatic logic [6:0] ones_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    tens_an  = 2'b01;
    tens_seg = ONE;
    unique case (1'b1)
      z_q: begin
        tens_an  = 2'b01;
        tens_seg = ONE;
      end
      !z_q: begin
`ifdef LEADING_ZERO_BLANK_EN
        tens_an  = 2'b11;
        tens_seg = BLANK;
`else
        tens_an  = 2'b01;
        tens_seg = ZERO;
`endif
      end
    endcase
  end

  // Display outputs change only on state entry, so a SHOW
  // state freezes whatever digit was held when it began.
  always_comb begin
    state_n = state;
    cnt_n   = cnt - 1'b1;
    an_n    = an;
    seg_n   = seg;
    if (cnt == '0) begin
      unique case (state)
        SHOW_ONES: begin
          state_n = GAP_A;
          cnt_n   = GAP_LD;
          an_n    = 2'b11;
          seg_n   = BLANK;
        end
        GAP_A: begin
          state_n = SHOW_TENS;
          cnt_n   = SCAN_LD;
          an_n    = tens_an;
          seg_n   = tens_seg;
        end
        SHOW_TENS: begin
          state_n = GAP_B;
          cnt_n   = GAP_LD;
          an_n    = 2'b11;
          seg_n   = BLANK;
        end
        GAP_B: begin
          state_n = SHOW_ONES;
          cnt_n   = SCAN_LD;
          an_n    = 2'b10;
          seg_n   = ones_seg(bcd_q);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= GAP_B;
      cnt   <= GAP_LD;
      an    <= 2'b11;
      seg   <= BLANK;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      an    <= an_n;
      seg   <= seg_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_q   <= 1'b0;
      bcd_q <= 4'd0;
      err   <= 1'b0;
    end else if (load) begin
      z_q   <= z;
      bcd_q <= bcd;
      err   <= (bcd > 4'd9);
    end
  end

endmodule
